// File: rtl/logic_eval_arbiter_pkg.sv
// Shared definitions for the logic evaluator arbiter: FSM encoding and a
// constant ceiling-log2 helper used to size index and counter fields.
package logic_eval_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/logic_eval_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first request
// strictly above last_grant, wrapping around to the lowest index.
module rr_arbiter
   import logic_eval_arbiter_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_grant_i,
   output logic [NREQ-1:0] grant_o
);

   logic [IDW:0]      shamt_s;
   logic [NREQ-1:0]   upper_s;
   logic [NREQ-1:0]   src_s;

   // Mask off everything at or below last_grant; fall back to the full set on wrap.
   always_comb begin
      shamt_s = {1'b0, last_grant_i} + {{IDW{1'b0}}, 1'b1};
      upper_s = req_i & ({NREQ{1'b1}} << shamt_s);
      src_s   = (|upper_s) ? upper_s : req_i;
      grant_o = src_s & (~src_s + {{(NREQ-1){1'b0}}, 1'b1});
   end

endmodule

// File: rtl/logic_eval_arbiter.sv
// Time-shares one combinational evaluator among NREQ requesters: grant, drive
// the vector for SETTLE cycles, sample the result and return it tagged.
module logic_eval_arbiter
   import logic_eval_arbiter_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int WIDTH  = 6,
   parameter  int SETTLE = 1,
   parameter  int CNTW   = 16,
   localparam int IDW    = clog2(NREQ),
   localparam int SW     = (SETTLE > 1) ? clog2(SETTLE) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NREQ-1:0]         req_valid_i,
   input  logic [NREQ*WIDTH-1:0]   req_data_i,
   output logic [NREQ-1:0]         req_ready_o,
   output logic [WIDTH-1:0]        eval_x_o,
   input  logic                    eval_out_i,
   output logic                    rsp_valid_o,
   output logic [IDW-1:0]          rsp_id_o,
   output logic                    rsp_bit_o,
   output logic                    busy_o,
   output logic [CNTW-1:0]         txn_count_o
);

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [IDW-1:0]   cur_id_q, cur_id_d;
   logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
   logic [WIDTH-1:0] eval_x_q, eval_x_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic             rsp_bit_q, rsp_bit_d;
   logic [CNTW-1:0]  txn_count_q, txn_count_d;

   logic [NREQ-1:0]  grant_s;
   logic [IDW-1:0]   grant_idx_s;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i        (req_valid_i),
      .last_grant_i (last_grant_q),
      .grant_o      (grant_s)
   );

   // Encode the one-hot grant into a requester index.
   always_comb begin
      grant_idx_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_idx_s = grant_idx_s | (grant_s[i] ? IDW'(i) : '0);
      end
   end

   assign req_ready_o = (state_q == ST_IDLE) ? grant_s : '0;

   // Next-state logic for the accept / settle / respond sequence.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      settle_cnt_d = settle_cnt_q;
      eval_x_d     = eval_x_q;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_bit_d    = rsp_bit_q;
      txn_count_d  = txn_count_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant_s) begin
               eval_x_d     = req_data_i[grant_idx_s*WIDTH +: WIDTH];
               cur_id_d     = grant_idx_s;
               last_grant_d = grant_idx_s;
               settle_cnt_d = SW'(SETTLE - 1);
               state_d      = ST_DRIVE;
            end else begin
               state_d      = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (settle_cnt_q == '0) begin
               rsp_bit_d   = eval_out_i;
               rsp_id_d    = cur_id_q;
               rsp_valid_d = 1'b1;
               txn_count_d = txn_count_q + CNTW'(1);
               state_d     = ST_RESP;
            end else begin
               settle_cnt_d = settle_cnt_q - SW'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; last_grant resets to the top index so requester 0 wins first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         cur_id_q     <= '0;
         settle_cnt_q <= '0;
         eval_x_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_bit_q    <= 1'b0;
         txn_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         settle_cnt_q <= settle_cnt_d;
         eval_x_q     <= eval_x_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_bit_q    <= rsp_bit_d;
         txn_count_q  <= txn_count_d;
      end
   end

   assign eval_x_o    = eval_x_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_bit_o   = rsp_bit_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign txn_count_o = txn_count_q;

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Bench for logic_eval_arbiter: a default instance and a SETTLE=3/CNTW=4 instance,
// each shadowed by a transaction-level model evaluated once per cycle.
module tb_logic_eval_arbiter;

   typedef struct {
      logic [3:0]  mask;
      logic [23:0] data;
      int          exp_id;
      int          exp_bit;
      int          exp_cnt;
      int          exp_gap;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rv [2];
   logic [23:0] rd [2];
   logic [3:0]  rdy0, rdy1;
   logic [5:0]  ex0, ex1;
   logic        eo0, eo1;
   logic        rspv0, rspv1;
   logic [1:0]  rid0, rid1;
   logic        rbit0, rbit1;
   logic        bsy0, bsy1;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;

   always #5 clk = ~clk;

   assign eo0 = ^ex0;
   assign eo1 = ^ex1;

   logic_eval_arbiter #(.NREQ(4), .WIDTH(6), .SETTLE(1), .CNTW(16)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[0]), .req_data_i(rd[0]),
      .req_ready_o(rdy0), .eval_x_o(ex0), .eval_out_i(eo0), .rsp_valid_o(rspv0),
      .rsp_id_o(rid0), .rsp_bit_o(rbit0), .busy_o(bsy0), .txn_count_o(cnt0)
   );

   logic_eval_arbiter #(.NREQ(4), .WIDTH(6), .SETTLE(3), .CNTW(4)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[1]), .req_data_i(rd[1]),
      .req_ready_o(rdy1), .eval_x_o(ex1), .eval_out_i(eo1), .rsp_valid_o(rspv1),
      .rsp_id_o(rid1), .rsp_bit_o(rbit1), .busy_o(bsy1), .txn_count_o(cnt1)
   );

   int         nchk = 0, npass = 0, cyc = 0;
   int         m_last [2], m_idle [2], m_resp [2], m_cnt [2], m_id [2];
   logic [5:0] m_ex [2];
   logic       m_bit [2];
   logic [3:0] acc_seen [2], sticky [2];
   int         act_acc [2];
   bit         got [2];
   int         got_id [2], got_bit [2], got_cnt [2], got_cyc [2];
   bit         rand_mode = 1'b0;

   task automatic chk(input string name, input int d, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, d, cyc, act, exp);
   endtask

   task automatic fail_now(input string name);
      nchk++;
      $display("FAIL %s: bound expired at cyc %0d", name, cyc);
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (v[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   // Reference: one transaction at a time, accept at E, answer at E+S, idle again at E+S+1.
   task automatic model();
      logic [3:0] rdy_s, exp_rdy;
      logic [5:0] ex_s;
      logic       rspv_s, rbit_s, bsy_s;
      int         rid_s, cnt_s, s, md, pick;
      for (int d = 0; d < 2; d++) begin
         rdy_s  = (d == 0) ? rdy0 : rdy1;
         ex_s   = (d == 0) ? ex0 : ex1;
         rspv_s = (d == 0) ? rspv0 : rspv1;
         rbit_s = (d == 0) ? rbit0 : rbit1;
         bsy_s  = (d == 0) ? bsy0 : bsy1;
         rid_s  = (d == 0) ? int'(rid0) : int'(rid1);
         cnt_s  = (d == 0) ? int'(cnt0) : int'(cnt1);
         s      = (d == 0) ? 1 : 3;
         md     = (d == 0) ? 65536 : 16;
         if (!rst_n) begin
            m_last[d] = 3; m_idle[d] = 0; m_resp[d] = -1; m_cnt[d] = 0; m_ex[d] = 6'd0;
            acc_seen[d] = 4'd0;
            chk("rst_eval_x", d, int'(ex_s), 0);
            chk("rst_busy", d, int'(bsy_s), 0);
            chk("rst_rsp_valid", d, int'(rspv_s), 0);
            chk("rst_txn_count", d, cnt_s, 0);
         end else begin
            pick    = rr_pick(rv[d], m_last[d]);
            exp_rdy = (cyc >= m_idle[d] && pick >= 0) ? 4'(4'b0001 << pick) : 4'd0;
            chk("req_ready", d, int'(rdy_s), int'(exp_rdy));
            chk("busy", d, int'(bsy_s), (cyc < m_idle[d]) ? 1 : 0);
            chk("eval_x", d, int'(ex_s), int'(m_ex[d]));
            chk("rsp_valid", d, int'(rspv_s), (cyc == m_resp[d]) ? 1 : 0);
            if (rspv_s) begin
               got[d] = 1'b1; got_id[d] = rid_s; got_bit[d] = int'(rbit_s);
               got_cnt[d] = cnt_s; got_cyc[d] = cyc;
            end
            if (cyc == m_resp[d]) begin
               chk("rsp_id", d, rid_s, m_id[d]);
               chk("rsp_bit", d, int'(rbit_s), int'(m_bit[d]));
               chk("txn_count", d, cnt_s, m_cnt[d]);
            end
            acc_seen[d] = rdy_s & rv[d];
            if (acc_seen[d] != 4'd0) act_acc[d] = cyc + 1;
            if (exp_rdy != 4'd0) begin
               m_last[d] = pick;
               m_ex[d]   = rd[d][pick*6 +: 6];
               m_id[d]   = pick;
               m_bit[d]  = ^m_ex[d];
               m_resp[d] = cyc + 1 + s;
               m_idle[d] = cyc + 2 + s;
               m_cnt[d]  = (m_cnt[d] + 1) % md;
            end
         end
      end
   endtask

   // One clock: check at the falling edge, then update requesters just after the rising edge.
   task automatic step();
      @(negedge clk);
      model();
      @(posedge clk);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_seen[d][i]) begin
               rv[d][i] = sticky[d][i];
               rd[d][i*6 +: 6] = 6'($urandom_range(0, 63));
            end
            if (rand_mode && !rv[d][i] && $urandom_range(0, 3) == 0) begin
               rv[d][i] = 1'b1;
               rd[d][i*6 +: 6] = 6'($urandom_range(0, 63));
            end
         end
         acc_seen[d] = 4'd0;
      end
   endtask

   task automatic wait_rsp(input int d, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         step();
         if (got[d]) begin
            ok = 1'b1;
            got[d] = 1'b0;
         end
      end
      if (!ok) fail_now("rsp_timeout");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      got[0] = 1'b0;
      got[1] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [8];
      bit   ok;
      int   prev_cyc, e, ids [4];
      logic [5:0] v;

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rv[d] = 4'd0; rd[d] = 24'd0; sticky[d] = 4'd0; got[d] = 1'b0;
         act_acc[d] = -1; acc_seen[d] = 4'd0;
      end
      step(); step(); step();
      rst_n = 1'b1;

      // Single requests walking last_grant to 3, then all four at once.
      tbl[0] = '{4'b0001, 24'h000009, 0, 0, 1, 0};
      tbl[1] = '{4'b0010, 24'h000FC0, 1, 0, 2, 0};
      tbl[2] = '{4'b0100, 24'h007000, 2, 1, 3, 0};
      tbl[3] = '{4'b1000, 24'hA80000, 3, 1, 4, 0};
      tbl[4] = '{4'b1111, 24'h103081, 0, 1, 5, 0};
      tbl[5] = '{4'b0000, 24'h000000, 1, 1, 6, 3};
      tbl[6] = '{4'b0000, 24'h000000, 2, 0, 7, 3};
      tbl[7] = '{4'b0000, 24'h000000, 3, 1, 8, 3};
      prev_cyc = 0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (tbl[k].mask[i]) begin
               rv[0][i] = 1'b1;
               rd[0][i*6 +: 6] = tbl[k].data[i*6 +: 6];
            end
         end
         wait_rsp(0, ok);
         if (ok) begin
            chk("tbl_id", k, got_id[0], tbl[k].exp_id);
            chk("tbl_bit", k, got_bit[0], tbl[k].exp_bit);
            chk("tbl_cnt", k, got_cnt[0], tbl[k].exp_cnt);
            if (tbl[k].exp_gap != 0) chk("tbl_gap", k, got_cyc[0] - prev_cyc, tbl[k].exp_gap);
            prev_cyc = got_cyc[0];
         end
      end
      repeat (3) step();

      // req0 and req2 continuously requesting alternate.
      do_reset();
      sticky[0] = 4'b0101;
      rv[0] = 4'b0101;
      rd[0] = 24'h02A015;
      ids = '{0, 2, 0, 2};
      for (int k = 0; k < 4; k++) begin
         wait_rsp(0, ok);
         if (ok) chk("alt_id", k, got_id[0], ids[k]);
      end
      sticky[0] = 4'd0;
      rv[0] = 4'd0;
      repeat (5) step();

      // Asynchronous reset while driving aborts the transaction.
      do_reset();
      act_acc[0] = -1;
      rv[0][0] = 1'b1;
      rd[0][5:0] = 6'b000011;
      for (int n = 0; n < 20 && act_acc[0] != cyc; n++) step();
      if (act_acc[0] != cyc) fail_now("abort_accept");
      rst_n = 1'b0;
      #1;
      chk("abort_eval_x", 0, int'(ex0), 0);
      chk("abort_busy", 0, int'(bsy0), 0);
      rv[0] = 4'b0011;
      rd[0][11:0] = {6'b000011, 6'b000001};
      step();
      step();
      rst_n = 1'b1;
      got[0] = 1'b0;
      wait_rsp(0, ok);
      if (ok) begin
         chk("post_rst_id", 0, got_id[0], 0);
         chk("post_rst_bit", 0, got_bit[0], 1);
      end
      wait_rsp(0, ok);
      if (ok) begin
         chk("post_rst_id2", 0, got_id[0], 1);
         chk("post_rst_bit2", 0, got_bit[0], 0);
      end
      repeat (3) step();

      // SETTLE=3: vector held four cycles, answer three edges after accept.
      act_acc[1] = -1;
      rv[1][2] = 1'b1;
      rd[1][17:12] = 6'b110100;
      for (int n = 0; n < 20 && act_acc[1] != cyc; n++) step();
      if (act_acc[1] != cyc) fail_now("settle_accept");
      e = cyc;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) step();
         chk("settle_eval_x", j, int'(ex1), 52);
         chk("settle_busy", j, int'(bsy1), 1);
      end
      wait_rsp(1, ok);
      if (ok) begin
         chk("settle_rsp_cyc", 1, got_cyc[1], e + 3);
         chk("settle_id", 1, got_id[1], 2);
         chk("settle_bit", 1, got_bit[1], 1);
      end
      repeat (3) step();

      // CNTW=4 counter wraps after 15.
      do_reset();
      for (int t = 0; t < 17; t++) begin
         v = 6'($urandom_range(0, 63));
         rv[1][t % 4] = 1'b1;
         rd[1][(t % 4)*6 +: 6] = v;
         wait_rsp(1, ok);
         if (ok) begin
            chk("wrap_cnt", t, got_cnt[1], (t + 1) % 16);
            chk("wrap_bit", t, got_bit[1], int'(^v));
            chk("wrap_id", t, got_id[1], t % 4);
         end
      end
      repeat (3) step();

      // Random traffic on both instances against the model.
      rand_mode = 1'b1;
      repeat (600) step();
      rand_mode = 1'b0;
      for (int n = 0; n < 200 && (rv[0] != 4'd0 || rv[1] != 4'd0); n++) step();
      if (rv[0] != 4'd0 || rv[1] != 4'd0) fail_now("drain");
      repeat (8) step();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
